// File: rtl/dispatch_if.sv
// Fetch / backpressure / decode bundle for dispatch_ctrl.
// slave  : the dispatch controller (consumes in_*, drives out_*).
// master : the environment around it (fetch, ROB/RS/LSQ, commit, decode).
interface dispatch_if;
  logic        in_fetch_valid;
  logic [31:0] in_fetch_inst;
  logic [31:0] in_fetch_pc;
  logic        in_fetch_pred_taken;
  logic        out_fetch_ready;
  logic        in_rob_full;
  logic        in_rs_full;
  logic        in_lsq_full;
  logic        in_flush;
  logic        out_decode_ena;
  logic [31:0] out_decode_inst;
  logic [31:0] out_decode_pc;
  logic        out_decode_pred_taken;
  logic [31:0] out_issue_count;

  modport slave (
    input  in_fetch_valid, in_fetch_inst, in_fetch_pc, in_fetch_pred_taken,
    input  in_rob_full, in_rs_full, in_lsq_full, in_flush,
    output out_fetch_ready, out_decode_ena, out_decode_inst, out_decode_pc,
    output out_decode_pred_taken, out_issue_count
  );

  modport master (
    output in_fetch_valid, in_fetch_inst, in_fetch_pc, in_fetch_pred_taken,
    output in_rob_full, in_rs_full, in_lsq_full, in_flush,
    input  out_fetch_ready, out_decode_ena, out_decode_inst, out_decode_pc,
    input  out_decode_pred_taken, out_issue_count
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// In-order dispatch controller: a circular instruction queue between fetch and
// decode, with structural backpressure from ROB/RS/LSQ and a timed flush hold.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - dispatch_if.slave: fetch push, full flags, flush, decode head, issue count
module dispatch_ctrl #(
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  dispatch_if.slave bus
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned FcW  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [OccW-1:0] OccFull = OccW'(QUEUE_DEPTH);
  localparam logic [FcW-1:0]  FcLoad  = FcW'(FLUSH_CYCLES);
  localparam logic [6:0]      OpLoad  = 7'b0000011;
  localparam logic [6:0]      OpStore = 7'b0100011;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic [FcW-1:0]  fcnt_q, fcnt_d;
  logic [31:0]     issue_cnt_q, issue_cnt_d;

  // Queue storage is never reset; contents are only visible once pushed.
  logic [31:0] inst_mem [QUEUE_DEPTH];
  logic [31:0] pc_mem   [QUEUE_DEPTH];
  logic        pred_mem [QUEUE_DEPTH];

  logic fetch_ready;
  logic decode_ena;
  logic head_is_mem;
  logic push;
  logic pop;

  assign head_is_mem = (inst_mem[head_q][6:0] == OpLoad) || (inst_mem[head_q][6:0] == OpStore);

  // Ready depends on registered state only, so fetch never sees a comb path.
  assign fetch_ready = (state_q == StRun) && (occ_q != OccFull);

  // A flush in the same cycle kills the dispatch before decode latches it.
  assign decode_ena = (state_q == StRun) && (occ_q != '0) && !bus.in_rob_full &&
                      !bus.in_rs_full && (!bus.in_lsq_full || !head_is_mem) && !bus.in_flush;

  assign push = bus.in_fetch_valid && fetch_ready;
  assign pop  = decode_ena;

  assign bus.out_fetch_ready       = fetch_ready;
  assign bus.out_decode_ena        = decode_ena;
  assign bus.out_decode_inst       = inst_mem[head_q];
  assign bus.out_decode_pc         = pc_mem[head_q];
  assign bus.out_decode_pred_taken = pred_mem[head_q];
  assign bus.out_issue_count       = issue_cnt_q;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    fcnt_d      = fcnt_q;
    issue_cnt_d = issue_cnt_q;
    unique case (state_q)
      StRun: begin
        if (bus.in_flush) begin
          state_d = StFlush;
          head_d  = '0;
          tail_d  = '0;
          occ_d   = '0;
          fcnt_d  = FcLoad;
        end else begin
          if (push) tail_d = tail_q + 1'b1;
          if (pop) begin
            head_d      = head_q + 1'b1;
            issue_cnt_d = issue_cnt_q + 32'd1;
          end
          if (push && !pop) begin
            occ_d = occ_q + 1'b1;
          end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
          end
        end
      end
      StFlush: begin
        if (bus.in_flush) begin
          fcnt_d = FcLoad;
        end else if (fcnt_q <= FcW'(1)) begin
          fcnt_d  = '0;
          state_d = StRun;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      fcnt_q      <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      fcnt_q      <= fcnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !bus.in_flush && !rst) begin
      inst_mem[tail_q] <= bus.in_fetch_inst;
      pc_mem[tail_q]   <= bus.in_fetch_pc;
      pred_mem[tail_q] <= bus.in_fetch_pred_taken;
    end
  end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 SHALL take parameter QUEUE_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 SHALL take parameter FLUSH_CYCLES, default 2, cycles to hold dispatch after a flush (>=1).
REQ-003 SHALL have clock and reset as decided: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_fetch_valid  input  1  fetch presents an instruction this cycle.
REQ-007 in_fetch_inst  input  32  fetched instruction word.
REQ-008 in_fetch_pc  input  32  PC of the fetched instruction.
REQ-009 in_fetch_pred_taken  input  1  branch-predictor decision for that instruction.
REQ-010 out_fetch_ready  output  1  queue accepts a push this cycle.
REQ-011 in_rob_full  input  1  ROB cannot take another assignment; downstream asserts it with one slot of margin.
REQ-012 in_rs_full  input  1  RS cannot take another entry; asserted with one slot of margin.
REQ-013 in_lsq_full  input  1  LS queue cannot take another entry; asserted with one slot of margin.
REQ-014 in_flush  input  1  misprediction or exception flush request from commit.
REQ-015 out_decode_ena  output  1  decode-stage enable; decode latches the head on this edge.
REQ-016 out_decode_inst  output  32  queue-head instruction.
REQ-017 out_decode_pc  output  32  queue-head PC.
REQ-018 out_decode_pred_taken  output  1  queue-head prediction bit.
REQ-019 out_issue_count  output  32  total instructions dispatched since reset.

Function
REQ-020 SHALL hold a circular FIFO of {inst, pc, pred_taken}, with head and tail pointers of log2(QUEUE_DEPTH) bits that wrap modulo QUEUE_DEPTH, plus an occupancy counter from 0 to QUEUE_DEPTH.
REQ-021 SHALL have two states: RUN and FLUSH.
REQ-022 out_fetch_ready SHALL be 1 exactly when the state is RUN and occupancy < QUEUE_DEPTH; it is driven from registered state only.
REQ-023 A push SHALL occur on an edge where in_fetch_valid and out_fetch_ready are both 1; the entry is written at tail, and tail advances.
REQ-024 A head instruction is a memory op when inst[6:0] is 0000011 (load) or 0100011 (store).
REQ-025 out_decode_ena SHALL be combinational: state RUN, occupancy > 0, !in_rob_full, !in_rs_full, and (!in_lsq_full or the head is not a memory op).
REQ-026 When out_decode_ena is 1, head SHALL advance on that edge (pop) and out_issue_count SHALL increment, wrapping at 2^32.
REQ-027 out_decode_inst, out_decode_pc and out_decode_pred_taken SHALL always show the head entry; they are don't-care when the queue is empty.
REQ-028 Head-to-decode latency SHALL be 0 cycles; an instruction pushed at edge N is dispatchable in the cycle after edge N, with no same-cycle bypass.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged and SHALL be legal at any occupancy between 1 and QUEUE_DEPTH-1.
REQ-030 Unknown opcodes SHALL be dispatched like any non-memory op; decode turns them into NOP.
REQ-031 Dispatch SHALL be strictly in order: a stalled head blocks all younger entries.
REQ-032 On in_flush in RUN: clear occupancy, head and tail to 0; discard any push and pop that edge; load the flush counter with FLUSH_CYCLES; go to FLUSH.
REQ-033 Because out_decode_ena is combinational, in_flush SHALL force out_decode_ena to 0 in that same cycle.
REQ-034 In FLUSH: out_fetch_ready = 0 and out_decode_ena = 0; the counter decrements each cycle; the state returns to RUN on the edge where the counter goes from 1 to 0.
REQ-035 in_flush asserted during FLUSH SHALL reload the counter with FLUSH_CYCLES and keep the queue empty.
REQ-036 Flush SHALL take priority over push, pop and the counter-increment; out_issue_count is not reset by flush.

Reset
REQ-037 On a clk edge with rst = 1: state RUN, occupancy 0, head 0, tail 0, flush counter 0, out_issue_count 0.
REQ-038 The resulting outputs SHALL be out_fetch_ready 1 and out_decode_ena 0; FIFO contents are not cleared.
REQ-039 rst SHALL override in_flush and all in-progress activity, including reset asserted during FLUSH.

Verification
REQ-040 Reset, then push 4 instructions with rob/rs/lsq full held at 1 -> occupancy 4, out_fetch_ready 0, out_decode_ena never 1.
REQ-041 Release full flags with queue holding ADDI@0x00 and LW@0x04, in_lsq_full = 1 -> ADDI dispatched, out_issue_count = 1; LW held with out_decode_ena 0 until in_lsq_full drops, then out_issue_count = 2.
REQ-042 Steady streaming, one push and one pop per cycle for 10 cycles, starting at occupancy 1 -> occupancy stays 1, PCs dispatched in order 0x00..0x24, with pointer wrap exercised.
REQ-043 Pulse in_flush with occupancy 3 while a push and a dispatch are also attempted -> no dispatch that cycle, occupancy 0, out_fetch_ready 0 for exactly 2 cycles, then 1.
REQ-044 Pulse in_flush again 1 cycle into FLUSH -> 2 further hold cycles counted from the second pulse.
REQ-045 Assert rst during FLUSH with occupancy 0 -> RUN with out_fetch_ready 1 on the next cycle and out_issue_count 0.
